// File: rtl/ucu_pkg.sv
// Shared definitions for the two-address microcode control unit:
// condition selects, microstate addresses and the microword layout.
package ucu_pkg;

   localparam logic [1:0] COND_GO   = 2'b00;
   localparam logic [1:0] COND_ZERO = 2'b01;
   localparam logic [1:0] COND_AX   = 2'b10;
   localparam logic [1:0] COND_ONE  = 2'b11;

   localparam logic [2:0] WAIT  = 3'd0;
   localparam logic [2:0] TEST  = 3'd1;
   localparam logic [2:0] CHECK = 3'd2;
   localparam logic [2:0] INC   = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;
   localparam logic [2:0] SHIFT = 3'd5;

   // Control field order {ld_a, clr_cnt, inc_cnt, shift_a, done} in bits [4:0]
   localparam logic [4:0] CTL_NONE  = 5'b00000;
   localparam logic [4:0] CTL_WAIT  = 5'b11000;
   localparam logic [4:0] CTL_INC   = 5'b00100;
   localparam logic [4:0] CTL_SHIFT = 5'b00010;
   localparam logic [4:0] CTL_DONE  = 5'b00001;

   typedef struct packed {
      logic [1:0] sel;
      logic [2:0] nst;
      logic [2:0] nsf;
      logic       ldA;
      logic       clrCnt;
      logic       incCnt;
      logic       shiftA;
      logic       done;
   } uword_t;

   function automatic uword_t mkWord(input logic [1:0] sel, input logic [2:0] nst,
                                     input logic [2:0] nsf, input logic [4:0] ctl);
      uword_t w;
      w.sel    = sel;
      w.nst    = nst;
      w.nsf    = nsf;
      w.ldA    = ctl[4];
      w.clrCnt = ctl[3];
      w.incCnt = ctl[2];
      w.shiftA = ctl[1];
      w.done   = ctl[0];
      return w;
   endfunction

endpackage

// File: rtl/ucode_ctrl_unit_if.sv
// Handshake and datapath-control bundle between the sequencer (slave)
// and the surrounding start/done logic plus ones-counting datapath (master).
interface ucode_ctrl_unit_if;

   logic       go;
   logic       a_zero;
   logic       ax;
   logic       ld_a;
   logic       clr_cnt;
   logic       inc_cnt;
   logic       shift_a;
   logic       done;
   logic [2:0] upc;

   modport master (
      output go, a_zero, ax,
      input  ld_a, clr_cnt, inc_cnt, shift_a, done, upc
   );

   modport slave (
      input  go, a_zero, ax,
      output ld_a, clr_cnt, inc_cnt, shift_a, done, upc
   );

endinterface

// File: rtl/ucu_cond_mux.sv
// Combinational 4:1 branch-condition selector for the microsequencer.
module ucu_cond_mux
   import ucu_pkg::*;
(
   input  logic [1:0] i_sel,
   input  logic       i_go,
   input  logic       i_a_zero,
   input  logic       i_ax,
   output logic       o_cond
);

   always_comb begin
      o_cond = 1'b1;
      case (i_sel)
         COND_GO:   o_cond = i_go;
         COND_ZERO: o_cond = i_a_zero;
         COND_AX:   o_cond = i_ax;
         COND_ONE:  o_cond = 1'b1;
         default:   o_cond = 1'b1;
      endcase
   end

endmodule

// File: rtl/ucode_ctrl_unit.sv
// Two-address microcode sequencer: uPC register, 8-word ROM and Moore decode
// of the datapath controls for the ones-counting engine.
module ucode_ctrl_unit
   import ucu_pkg::*;
#(
   parameter int UPC_W = 3
)(
   input  logic                clk,
   input  logic                rst_n,
   ucode_ctrl_unit_if.slave    bus
);

   logic [UPC_W-1:0] r_upc;
   logic [UPC_W-1:0] w_next;
   uword_t           w_word;
   logic             w_cond;

   // Unused addresses branch unconditionally to WAIT with every control idle
   always_comb begin
      w_word = mkWord(COND_ONE, WAIT, WAIT, CTL_NONE);
      case (r_upc)
         WAIT:    w_word = mkWord(COND_GO,   TEST,  WAIT,  CTL_WAIT);
         TEST:    w_word = mkWord(COND_ZERO, DONE,  CHECK, CTL_NONE);
         CHECK:   w_word = mkWord(COND_AX,   INC,   SHIFT, CTL_NONE);
         INC:     w_word = mkWord(COND_ONE,  SHIFT, SHIFT, CTL_INC);
         DONE:    w_word = mkWord(COND_GO,   DONE,  WAIT,  CTL_DONE);
         SHIFT:   w_word = mkWord(COND_ONE,  TEST,  TEST,  CTL_SHIFT);
         default: w_word = mkWord(COND_ONE,  WAIT,  WAIT,  CTL_NONE);
      endcase
   end

   ucu_cond_mux u_cond_mux (
      .i_sel    (w_word.sel),
      .i_go     (bus.go),
      .i_a_zero (bus.a_zero),
      .i_ax     (bus.ax),
      .o_cond   (w_cond)
   );

   always_comb begin
      w_next = w_word.nsf;
      if (w_cond) begin
         w_next = w_word.nst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_upc <= WAIT;
      end else begin
         r_upc <= w_next;
      end
   end

   assign bus.ld_a    = w_word.ldA;
   assign bus.clr_cnt = w_word.clrCnt;
   assign bus.inc_cnt = w_word.incCnt;
   assign bus.shift_a = w_word.shiftA;
   assign bus.done    = w_word.done;
   assign bus.upc     = r_upc;

endmodule
